instr_fetch_queue: RTL
======================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of instruction entries in the queue (power of two, 2..16).
REQ-002 The block SHALL have parameter PC_W, default 12, meaning the instruction-address width matching address_imem.
REQ-003 clock  input  1  single rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-low reset; reset=0 sampled at a rising edge resets all state.
REQ-005 address_imem  output  PC_W  registered fetch address presented to imem.
REQ-006 q_imem  input  32  imem read data, valid one cycle after its address.
REQ-007 redirect_valid  input  1  processor branch/jump redirect request.
REQ-008 redirect_pc  input  PC_W  redirect target address.
REQ-009 inst_valid  output  1  queue head holds a valid instruction.
REQ-010 inst  output  32  head instruction word.
REQ-011 inst_pc  output  PC_W  address of head instruction.
REQ-012 inst_ready  input  1  processor accepts head this cycle.

Function
REQ-013 A request SHALL issue in any cycle with reset=1, redirect_valid=0 and (occupancy + in-flight) < DEPTH; on issue, fetch_pc SHALL increment by 1 at the edge.
REQ-014 address_imem SHALL equal fetch_pc at all times.
REQ-015 A request issued in cycle t SHALL push {q_imem, its pc} into the queue at the end of cycle t+1, unless killed.
REQ-016 At most one request SHALL be in flight; in-flight state holds a valid bit plus the issued pc.
REQ-017 Head handshake: the head entry pops when inst_valid=1 and inst_ready=1; push and pop in the same cycle keep occupancy unchanged.
REQ-018 Occupancy checked for issue SHALL be the pre-pop value (no same-cycle credit from pop).
REQ-019 Push SHALL never occur when full; this is guaranteed by REQ-013.
REQ-020 fetch_pc SHALL wrap from 2^PC_W-1 to 0.
REQ-021 redirect_valid=1 SHALL, at that edge, empty the queue, kill the in-flight request, and load fetch_pc with redirect_pc; no request issues in that cycle.
REQ-022 A handshake coincident with redirect SHALL count as accepted; the flush still empties the queue.
REQ-023 After a redirect in cycle r, inst_valid SHALL be 0 in cycles r+1 and r+2, and inst_pc=redirect_pc with inst_valid=1 in cycle r+3, if no further redirect occurs.
REQ-024 inst and inst_pc SHALL be stable while inst_valid=1 and inst_ready=0.
REQ-025 Steady state with inst_ready held at 1 SHALL deliver one instruction every 2 cycles; with DEPTH≥2 and inst_ready=0, the queue SHALL fill to DEPTH and stop issuing.

Reset
REQ-026 On reset: fetch_pc=0, address_imem=0, queue empty, in-flight cleared, inst_valid=0, inst=0, inst_pc=0.
REQ-027 Reset mid-operation SHALL discard the queue and the in-flight request; a late q_imem SHALL NOT be pushed.
REQ-028 In the first cycle N with reset=1, address 0 SHALL issue; inst_valid=1 with inst_pc=0 SHALL appear in cycle N+2.

Configuration
REQ-029 Macro FETCH_STALL_COUNT_EN: when defined, the block SHALL add output stall_count (16 bits), which resets to 0 and increments, saturating at 16'hFFFF, in each cycle with reset=1 and inst_valid=0; when undefined, the port and the counter SHALL be absent and behaviour is otherwise identical.

Structure
REQ-030 Shared package fetch_pkg SHALL hold the PC_W default, the instruction width constant (32), the DEPTH default, and the queue entry type {inst, pc}.
REQ-031 The queue SHALL be a single sub-module fetch_fifo, a synchronous FIFO with push, pop and flush inputs, full/empty outputs, and count.

Verification
REQ-032 Reset release with inst_ready=1, imem holding word k = 32'h1000_0000+k -> inst_pc 0,1,2,3 delivered in cycles N+2, N+4, N+6, N+8 with the matching words.
REQ-033 inst_ready=0 from reset, DEPTH=4 -> exactly 4 requests issue (addresses 0..3), then address_imem holds 4; raising inst_ready pops 0..3 in order.
REQ-034 Redirect to 12'h200 while the queue holds 3 entries and a request is in flight -> queue empty next cycle; inst_valid=1 with inst_pc=12'h200 three cycles after the redirect cycle; no stale word appears.
REQ-035 Redirect to 12'hFFF -> pcs FFF then 000 delivered (wrap-around).
REQ-036 reset=0 asserted for one cycle during a pending fetch -> inst_valid=0 next cycle; restart at pc 0; no stale push.
REQ-037 With FETCH_STALL_COUNT_EN defined: after reset release with inst_ready=1, stall_count SHALL read 2 in cycle N+2 and 3 in cycle N+4.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and the queue entry type for the instruction fetch queue.
package fetch_pkg;

    localparam int PC_W_DEFAULT  = 12;
    localparam int INST_W        = 32;
    localparam int DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [INST_W-1:0]       inst;
        logic [PC_W_DEFAULT-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched entries with flush; the head is read combinationally
// so a pushed entry is visible at the output in the cycle after the push.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = DEPTH_DEFAULT,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  entry_t                   data_i,
    output entry_t                   head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   rd_ptr_d;
    logic [AW:0]     count_q;
    logic [AW:0]     count_d;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: pointers and count alone decide what is visible.
    always_ff @(posedge clk_i) begin
        if (rst_ni && do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: one outstanding imem request feeding a small queue.
// Optional macro FETCH_STALL_COUNT_EN adds a saturating stall_count output.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int PC_W  = PC_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    output logic [PC_W-1:0]   address_imem,
    input  logic [INST_W-1:0] q_imem,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
`ifdef FETCH_STALL_COUNT_EN
    output logic [15:0]       stall_count,
`endif
    input  logic              inst_ready
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } entry_t;

    logic [PC_W-1:0] fetch_pc_q;
    logic [PC_W-1:0] fetch_pc_d;
    logic            inflight_valid_q;
    logic            inflight_valid_d;
    logic [PC_W-1:0] inflight_pc_q;
    logic [PC_W-1:0] inflight_pc_d;

    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [AW:0]     fifo_count;
    logic [AW:0]     occupancy;
    entry_t          fifo_in;
    entry_t          fifo_head;
    logic            issue;

    // Occupancy is the pre-pop count, so a same-cycle pop never grants a new issue.
    assign occupancy = fifo_count + (AW+1)'(inflight_valid_q);
    assign issue     = reset & ~redirect_valid & ~inflight_valid_q
                     & (occupancy < (AW+1)'(DEPTH));

    assign fifo_push    = reset & ~redirect_valid & inflight_valid_q & ~fifo_full;
    assign fifo_pop     = inst_valid & inst_ready;
    assign fifo_in.inst = q_imem;
    assign fifo_in.pc   = inflight_pc_q;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (redirect_valid),
        .data_i  (fifo_in),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign address_imem = fetch_pc_q;
    assign inst_valid   = ~fifo_empty;
    assign inst         = inst_valid ? fifo_head.inst : '0;
    assign inst_pc      = inst_valid ? fifo_head.pc   : '0;

    always_comb begin
        fetch_pc_d       = fetch_pc_q;
        inflight_valid_d = inflight_valid_q;
        inflight_pc_d    = inflight_pc_q;
        if (redirect_valid) begin
            fetch_pc_d       = redirect_pc;
            inflight_valid_d = 1'b0;
        end else if (issue) begin
            inflight_valid_d = 1'b1;
            inflight_pc_d    = fetch_pc_q;
            fetch_pc_d       = fetch_pc_q + 1'b1;
        end else if (inflight_valid_q) begin
            // The outstanding response is pushed this cycle.
            inflight_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_pc_q       <= '0;
            inflight_valid_q <= 1'b0;
            inflight_pc_q    <= '0;
        end else begin
            fetch_pc_q       <= fetch_pc_d;
            inflight_valid_q <= inflight_valid_d;
            inflight_pc_q    <= inflight_pc_d;
        end
    end

`ifdef FETCH_STALL_COUNT_EN
    logic [15:0] stall_count_q;
    logic [15:0] stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (!inst_valid && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule
